vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/marvin_vga_pkg.sv | 17 +
 rtl/vga_fb_addr.sv | 27 ++
 rtl/vga_fb_arbiter.sv | 120 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/marvin_vga_pkg.sv
// rtl/marvin_vga_pkg.sv - shared pixel and RAM-slot ownership types for the VGA framebuffer path
package marvin_vga_pkg;

    typedef logic [11:0] color_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_CPU_RD,
        OWN_CPU_WR
    } owner_e;

    function automatic logic owner_is_cpu(input owner_e owner);
        return (owner == OWN_CPU_RD) || (owner == OWN_CPU_WR);
    endfunction

endpackage

// File: rtl/vga_fb_addr.sv
// rtl/vga_fb_addr.sv - maps a screen coordinate onto a framebuffer address and range flag
module vga_fb_addr #(
    parameter int FB_WIDTH   = 160,
    parameter int FB_HEIGHT  = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int ADDR_W     = 15
) (
    input  logic [15:0]     pix_x,
    input  logic [15:0]     pix_y,
    output logic [ADDR_W:0] disp_addr,
    output logic            in_range
);

    localparam int AW1 = ADDR_W + 1;

    logic [15:0] fb_x;
    logic [15:0] fb_y;

    // The extra address bit keeps row*width from wrapping onto a valid cell.
    always_comb begin
        fb_x      = pix_x >> SCALE_LOG2;
        fb_y      = pix_y >> SCALE_LOG2;
        in_range  = (32'(fb_x) < FB_WIDTH) && (32'(fb_y) < FB_HEIGHT);
        disp_addr = AW1'(32'(fb_y) * FB_WIDTH + 32'(fb_x));
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares one sync framebuffer RAM port between display refresh and CPU
module vga_fb_arbiter
    import marvin_vga_pkg::*;
#(
    parameter int FB_WIDTH   = 160,
    parameter int FB_HEIGHT  = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       pix_x,
    input  logic [15:0]       pix_y,
    output color_t            color,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [11:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output color_t            cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [11:0]       ram_wdata,
    input  logic [11:0]       ram_rdata
);

    localparam int FB_CELLS = FB_WIDTH * FB_HEIGHT;

    logic [ADDR_W:0] disp_addr;
    logic            disp_in_range;

    vga_fb_addr #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .SCALE_LOG2(SCALE_LOG2),
        .ADDR_W    (ADDR_W)
    ) u_addr (
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .disp_addr(disp_addr),
        .in_range (disp_in_range)
    );

    owner_e          owner;
    owner_e          tag_q;
    logic            cpu_oor;
    logic            oor_q;
    logic            blank_q;
    logic            fetched_q;
    logic [ADDR_W:0] last_addr_q;
    logic            disp_need;

    always_comb begin
        cpu_oor   = 32'(cpu_addr) >= FB_CELLS;
        disp_need = !rst && disp_in_range && (!fetched_q || (disp_addr != last_addr_q));
    end

    // Display refresh always takes the slot; the CPU only gets leftovers.
    always_comb begin
        owner     = OWN_NONE;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (rst) begin
            owner = OWN_NONE;
        end else if (disp_need) begin
            owner = OWN_DISP;
        end else if (cpu_req) begin
            owner = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
        end
        case (owner)
            OWN_DISP:   ram_addr = disp_addr[ADDR_W-1:0];
            OWN_CPU_RD: ram_addr = cpu_addr;
            OWN_CPU_WR: begin
                ram_addr  = cpu_addr;
                ram_we    = !cpu_oor;
                ram_wdata = cpu_wdata;
            end
            default:    ram_addr = '0;
        endcase
        cpu_ready = owner_is_cpu(owner);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= OWN_NONE;
            oor_q       <= 1'b0;
            blank_q     <= 1'b0;
            fetched_q   <= 1'b0;
            last_addr_q <= '0;
            color       <= '0;
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
            cpu_err     <= 1'b0;
        end else begin
            tag_q   <= owner;
            oor_q   <= cpu_oor;
            blank_q <= !disp_in_range;
            if (owner == OWN_DISP) begin
                fetched_q   <= 1'b1;
                last_addr_q <= disp_addr;
            end

            // Second stage: route the RAM word to whoever owned last cycle.
            cpu_rvalid <= (tag_q == OWN_CPU_RD);
            cpu_err    <= owner_is_cpu(tag_q) && oor_q;
            if (tag_q == OWN_CPU_RD) begin
                cpu_rdata <= oor_q ? color_t'(0) : ram_rdata;
            end
            if (tag_q == OWN_DISP) begin
                color <= ram_rdata;
            end else if (blank_q) begin
                color <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed bench with a cycle-level reference model of the arbiter
module tb_vga_fb_arbiter;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int S     = 2;
    localparam int AW    = 15;
    localparam int CELLS = W * H;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   pix_x = '0;
    logic [15:0]   pix_y = '0;
    logic [11:0]   color;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [11:0]   cpu_wdata = '0;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [11:0]   cpu_rdata;
    logic          cpu_err;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [11:0]   ram_wdata;
    logic [11:0]   ram_rdata = '0;

    vga_fb_arbiter #(.FB_WIDTH(W), .FB_HEIGHT(H), .SCALE_LOG2(S), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .color(color),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [11:0] ram   [0:DEPTH-1];
    logic [11:0] m_mem [0:DEPTH-1];

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // reference state: fetch history, visible outputs, one pending op per requester
    bit          m_fetched;
    int          m_last;
    logic [11:0] m_color, m_rdata;
    bit          m_rvalid, m_err;
    int          pd, pc;
    logic [11:0] pdd, pdc;
    bit          poor;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void disp_calc(input logic [15:0] px, input logic [15:0] py,
                                      output bit inr, output int da);
        int sx, sy;
        sx  = int'(px) >> S;
        sy  = int'(py) >> S;
        inr = (sx < W) && (sy < H);
        da  = sy * W + sx;
    endfunction

    task automatic model_step();
        bit inr, need, rdy, oor;
        int da;
        if (rst) begin
            m_fetched = 0; m_last = 0; m_color = '0; m_rdata = '0;
            m_rvalid = 0; m_err = 0; pd = 0; pc = 0; poor = 0;
            return;
        end
        m_rvalid = (pc == 1);
        m_err    = (pc != 0) && poor;
        if (pc == 1) m_rdata = pdc;
        if (pd == 1) m_color = pdd;
        else if (pd == 2) m_color = '0;
        disp_calc(pix_x, pix_y, inr, da);
        need = inr && (!m_fetched || da != m_last);
        rdy  = !need && cpu_req;
        oor  = int'(cpu_addr) >= CELLS;
        pd   = need ? 1 : (inr ? 0 : 2);
        if (need) begin
            pdd = m_mem[da];
            m_fetched = 1;
            m_last = da;
        end
        pc   = !rdy ? 0 : (cpu_we ? 2 : 1);
        poor = oor;
        if (pc == 1) pdc = oor ? 12'h000 : m_mem[cpu_addr];
        if (pc == 2 && !oor) m_mem[cpu_addr] = cpu_wdata;
    endtask

    task automatic compare();
        bit inr, need, rdy, oor, e_we;
        int da, e_addr;
        disp_calc(pix_x, pix_y, inr, da);
        need   = !rst && inr && (!m_fetched || da != m_last);
        rdy    = !rst && !need && cpu_req;
        oor    = int'(cpu_addr) >= CELLS;
        e_we   = rdy && cpu_we && !oor;
        e_addr = need ? da : (rdy ? int'(cpu_addr) : 0);
        chk("cpu_ready", 32'(cpu_ready), 32'(rdy));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(cpu_wdata));
        chk("color", 32'(color), 32'(m_color));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rvalid));
        chk("cpu_err", 32'(cpu_err), 32'(m_err));
        if (m_rvalid) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
    endtask

    initial forever begin
        @(posedge clk);
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) compare();
    end

    task automatic cyc(input bit r, input int px, input int py, input bit req,
                       input bit we, input int addr, input int wd);
        @(posedge clk);
        #1;
        rst       = r;
        pix_x     = 16'(px);
        pix_y     = 16'(py);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = AW'(addr);
        cpu_wdata = 12'(wd);
        @(negedge clk);
    endtask

    int rc, fc;
    int fa [0:3];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]   = 12'(i) ^ 12'h5A5;
            m_mem[i] = 12'(i) ^ 12'h5A5;
        end
        ram[0] = 12'hF00; m_mem[0] = 12'hF00;
        ram[1] = 12'h123; m_mem[1] = 12'h123;
        ram[2] = 12'h2C4; m_mem[2] = 12'h2C4;

        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_on = 1'b1;
        chk("rst_color", 32'(color), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        cyc(1, 0, 0, 1, 0, 7, 0);
        chk("rst_ready", 32'(cpu_ready), 32'h0);

        // first fetch after reset, CPU read waits one cycle
        cyc(0, 0, 0, 1, 0, 7, 0);
        chk("c1_ready", 32'(cpu_ready), 32'h0);
        chk("c1_fetch_addr", 32'(ram_addr), 32'h0);
        cyc(0, 0, 0, 1, 0, 7, 0);
        chk("c2_ready", 32'(cpu_ready), 32'h1);
        chk("c2_ram_addr", 32'(ram_addr), 32'h7);
        chk("c2_color", 32'(color), 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("c3_color", 32'(color), 32'hF00);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("c4_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("c4_rdata", 32'(cpu_rdata), 32'h5A2);

        // walk pix_x across two scaled pixels with the CPU always asking
        cyc(1, 0, 0, 0, 0, 0, 0);
        rc = 0; fc = 0;
        for (int x = 0; x < 8; x++) begin
            cyc(0, x, 0, 1, 0, 100, 0);
            if (!cpu_ready) begin
                if (fc < 4) fa[fc] = int'(ram_addr);
                fc++;
            end else begin
                rc++;
            end
            if (x == 2) chk("walk_color_x2", 32'(color), 32'hF00);
            if (x == 6) chk("walk_color_x6", 32'(color), 32'h123);
        end
        chk("walk_ready_cnt", 32'(rc), 32'd6);
        chk("walk_fetch_cnt", 32'(fc), 32'd2);
        chk("walk_fetch0", 32'(fa[0]), 32'd0);
        chk("walk_fetch1", 32'(fa[1]), 32'd1);

        // CPU write collides with a display fetch, then reads back
        cyc(0, 8, 0, 1, 1, 5, 'h0A5);
        chk("wr_blocked", 32'(cpu_ready), 32'h0);
        chk("wr_blocked_addr", 32'(ram_addr), 32'h2);
        cyc(0, 8, 0, 1, 1, 5, 'h0A5);
        chk("wr_ready", 32'(cpu_ready), 32'h1);
        chk("wr_we", 32'(ram_we), 32'h1);
        chk("wr_addr", 32'(ram_addr), 32'h5);
        chk("wr_data", 32'(ram_wdata), 32'h0A5);
        cyc(0, 8, 0, 1, 0, 5, 0);
        chk("rd_ready", 32'(cpu_ready), 32'h1);
        chk("rd_color", 32'(color), 32'h2C4);
        cyc(0, 8, 0, 0, 0, 0, 0);
        cyc(0, 8, 0, 0, 0, 0, 0);
        chk("rd_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("rd_rdata", 32'(cpu_rdata), 32'h0A5);

        // out-of-range CPU accesses
        cyc(0, 8, 0, 1, 0, 19200, 0);
        chk("oor_rd_ready", 32'(cpu_ready), 32'h1);
        chk("oor_rd_we", 32'(ram_we), 32'h0);
        cyc(0, 8, 0, 0, 0, 0, 0);
        cyc(0, 8, 0, 0, 0, 0, 0);
        chk("oor_rd_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("oor_rd_rdata", 32'(cpu_rdata), 32'h0);
        chk("oor_rd_err", 32'(cpu_err), 32'h1);
        cyc(0, 8, 0, 1, 1, 20000, 'hFFF);
        chk("oor_wr_ready", 32'(cpu_ready), 32'h1);
        chk("oor_wr_we", 32'(ram_we), 32'h0);
        cyc(0, 8, 0, 0, 0, 0, 0);
        cyc(0, 8, 0, 0, 0, 0, 0);
        chk("oor_wr_err", 32'(cpu_err), 32'h1);
        chk("oor_wr_rvalid", 32'(cpu_rvalid), 32'h0);

        // horizontal blanking: no fetch, color drops to 0 two cycles later
        cyc(0, 640, 0, 1, 0, 3, 0);
        chk("blank_ready0", 32'(cpu_ready), 32'h1);
        cyc(0, 640, 0, 1, 0, 3, 0);
        chk("blank_ready1", 32'(cpu_ready), 32'h1);
        chk("blank_color1", 32'(color), 32'h2C4);
        cyc(0, 640, 0, 1, 0, 3, 0);
        chk("blank_ready2", 32'(cpu_ready), 32'h1);
        chk("blank_color2", 32'(color), 32'h0);

        // reset lands on a read in flight
        cyc(0, 640, 0, 0, 0, 0, 0);
        cyc(0, 640, 0, 1, 0, 3, 0);
        chk("inflight_accept", 32'(cpu_ready), 32'h1);
        cyc(1, 640, 0, 1, 0, 3, 0);
        chk("inrst_ready", 32'(cpu_ready), 32'h0);
        chk("inrst_addr", 32'(ram_addr), 32'h0);
        chk("inrst_we", 32'(ram_we), 32'h0);
        cyc(0, 640, 0, 0, 0, 0, 0);
        chk("postrst_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("postrst_color", 32'(color), 32'h0);
        chk("postrst_rdata", 32'(cpu_rdata), 32'h0);
        chk("postrst_err", 32'(cpu_err), 32'h0);

        // mixed traffic over a few scanlines, model-checked every cycle
        for (int i = 0; i < 48; i++) begin
            cyc(0, i * 2, 8 + (i / 24) * 4, (i % 3) != 0, (i % 2) == 1,
                40 + (i % 5), i * 77);
        end
        cyc(0, 700, 20, 0, 0, 0, 0);
        cyc(0, 700, 20, 0, 0, 0, 0);
        cyc(0, 700, 20, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
